// File: rtl/btb_predictor_pkg.sv
// btb_predictor_pkg: shared BTB constants, counter encodings and update-action type.
`default_nettype none

package btb_predictor_pkg;

    // Lowest PC bit used for the table index; PC[1:0] are always zero for word-aligned fetch.
    localparam int BTB_IDX_LSB = 2;

    // Direction counter encodings for the default 2-bit counter.
    localparam logic [1:0] CNT2_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT2_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT2_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT2_STRONG_T  = 2'b11;

    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,
        UPD_ALLOC = 2'd2
    } upd_action_e;

endpackage

`default_nettype wire

// File: rtl/btb_predictor_sat_counter.sv
// sat_counter: saturating up/down counter with synchronous load and async active-low reset.
`default_nettype none

module sat_counter #(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;

    // Load wins; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (inc && !dec && (count != MAX_VALUE)) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with per-entry saturating direction counters,
// combinational lookup, MEM-stage training, mispredict detection and perf counters.
`default_nettype none

module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_en,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    input  logic                  flush_all,
    output logic [STAT_WIDTH-1:0] perf_lookups,
    output logic [STAT_WIDTH-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - BTB_IDX_LSB;
    localparam int IDX_HI = IDX_W + BTB_IDX_LSB - 1;

    localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T  = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = CNT_WIDTH'(CNT_WEAK_T - CNT_WIDTH'(1));

    logic [ENTRIES-1:0]    valid;
    logic [TAG_W-1:0]      tag_mem    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_mem [ENTRIES];
    logic [CNT_WIDTH-1:0]  cnt_mem    [ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [TAG_W-1:0] pred_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    upd_action_e      upd_action;
    logic [ENTRIES-1:0] upd_sel;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IDX_HI:BTB_IDX_LSB];
    assign pred_tag = pred_pc[ADDR_WIDTH-1:IDX_HI+1];
    assign upd_idx  = upd_pc[IDX_HI:BTB_IDX_LSB];
    assign upd_tag  = upd_pc[ADDR_WIDTH-1:IDX_HI+1];
    assign unused_pc_bits = ^{pred_pc[BTB_IDX_LSB-1:0], upd_pc[BTB_IDX_LSB-1:0]};

    // Lookup reads the registered table only, so a same-cycle update is not visible yet.
    assign pred_hit    = valid[pred_idx] && (tag_mem[pred_idx] == pred_tag);
    assign pred_taken  = pred_hit && cnt_mem[pred_idx][CNT_WIDTH-1];
    assign pred_target = pred_taken ? target_mem[pred_idx] : pred_pc + ADDR_WIDTH'(4);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    // A flush suppresses any coincident training or allocation.
    always_comb begin
        upd_action = UPD_NONE;
        if (upd_valid && !flush_all) begin
            if (upd_hit) begin
                upd_action = UPD_TRAIN;
            end else if (upd_taken) begin
                upd_action = UPD_ALLOC;
            end
        end
    end

    always_comb begin
        upd_sel = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            upd_sel[i] = (upd_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (flush_all) begin
                    valid[i] <= 1'b0;
                end else if (upd_sel[i] && (upd_action == UPD_ALLOC)) begin
                    valid[i] <= 1'b1;
                end
                if (upd_sel[i] && (upd_action == UPD_ALLOC)) begin
                    tag_mem[i] <= upd_tag;
                end
                if (upd_sel[i] && ((upd_action == UPD_ALLOC) ||
                                   ((upd_action == UPD_TRAIN) && upd_taken))) begin
                    target_mem[i] <= upd_target;
                end
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry_cnt
        sat_counter #(
            .WIDTH       (CNT_WIDTH),
            .RESET_VALUE (CNT_WEAK_NT)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (upd_sel[g] && (upd_action == UPD_ALLOC)),
            .load_value (CNT_WEAK_T),
            .inc        (upd_sel[g] && (upd_action == UPD_TRAIN) && upd_taken),
            .dec        (upd_sel[g] && (upd_action == UPD_TRAIN) && !upd_taken),
            .count      (cnt_mem[g])
        );
    end

    sat_counter #(
        .WIDTH       (STAT_WIDTH),
        .RESET_VALUE ('0)
    ) u_perf_lookups (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (1'b0),
        .load_value ('0),
        .inc        (pred_en),
        .dec        (1'b0),
        .count      (perf_lookups)
    );

    sat_counter #(
        .WIDTH       (STAT_WIDTH),
        .RESET_VALUE ('0)
    ) u_perf_mispredicts (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (1'b0),
        .load_value ('0),
        .inc        (mispredict),
        .dec        (1'b0),
        .count      (perf_mispredicts)
    );

endmodule

`default_nettype wire
